// File: rtl/grey_count_monitor.sv
// rtl/grey_count_monitor.sv - Gray-code input monitor: synchronize, decode, classify steps
// Counts up-wraps and illegal multi-bit steps; sticky fault cleared by clr_err.
module grey_count_monitor #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] g_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             up,
  output logic             step_err,
  output logic [3:0]       err_cnt,
  output logic [7:0]       wrap_cnt
);

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;

  localparam int               CW      = $clog2(SYNC_STAGES + 2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] g_prev_q, g_prev_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             step_err_q, step_err_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;
  logic [CW-1:0]    init_cnt_q, init_cnt_d;
  state_t           state_q, state_d;

  logic [WIDTH-1:0] g_s, bin_s, bin_prev, diff;
  logic             one_bit, multi_bit, stepped_up;
  logic [3:0]       err_base;

  always_comb begin
    sync_d[0] = g_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];

    g_s        = sync_q[SYNC_STAGES-1];
    bin_s      = gray2bin(g_s);
    bin_prev   = gray2bin(g_prev_q);
    diff       = g_s ^ g_prev_q;
    one_bit    = (diff != '0) && ((diff & (diff - ONE)) == '0);
    multi_bit  = (diff != '0) && !one_bit;
    stepped_up = (bin_s == bin_prev + ONE);
    err_base   = clr_err ? 4'd0 : err_cnt_q;

    g_prev_d   = g_s;
    bin_out_d  = bin_s;
    valid_d    = 1'b0;
    up_d       = up_q;
    step_err_d = step_err_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    init_cnt_d = init_cnt_q;
    state_d    = state_q;

    case (state_q)
      // Pipeline fill: g_prev is not trustworthy until the chain and g_prev are loaded.
      ST_INIT: begin
        if (init_cnt_q == CW'(SYNC_STAGES)) state_d = ST_TRACK;
        else init_cnt_d = init_cnt_q + CW'(1);
      end
      default: begin
        if (one_bit) begin
          valid_d = 1'b1;
          up_d    = stepped_up;
          if (stepped_up && (bin_prev == BIN_MAX) && (wrap_cnt_q != 8'hFF))
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
        // An illegal step on the clearing edge still counts, starting from zero.
        if (multi_bit) begin
          state_d    = ST_FAULT;
          step_err_d = 1'b1;
          err_cnt_d  = (err_base == 4'hF) ? err_base : err_base + 4'd1;
        end else if (clr_err) begin
          state_d    = ST_TRACK;
          step_err_d = 1'b0;
          err_cnt_d  = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      g_prev_q   <= '0;
      bin_out_q  <= '0;
      valid_q    <= 1'b0;
      up_q       <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= 4'd0;
      wrap_cnt_q <= 8'd0;
      init_cnt_q <= '0;
      state_q    <= ST_INIT;
    end else begin
      sync_q     <= sync_d;
      g_prev_q   <= g_prev_d;
      bin_out_q  <= bin_out_d;
      valid_q    <= valid_d;
      up_q       <= up_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      init_cnt_q <= init_cnt_d;
      state_q    <= state_d;
    end
  end

  assign bin_out  = bin_out_q;
  assign valid    = valid_q;
  assign up       = up_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_grey_count_monitor.sv
// tb/tb_grey_count_monitor.sv - directed scoreboard bench for grey_count_monitor
module tb_grey_count_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] g_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       valid;
  logic       up;
  logic       step_err;
  logic [3:0] err_cnt;
  logic [7:0] wrap_cnt;

  grey_count_monitor #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .g_in(g_in), .clr_err(clr_err),
    .bin_out(bin_out), .valid(valid), .up(up), .step_err(step_err),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       clr;
    logic [3:0] bin;
    logic       valid;
    logic       up;
    logic       serr;
    logic [3:0] ecnt;
    logic [7:0] wcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_prev;
  bit         m_first;
  logic       m_up;
  logic       m_serr;
  int         m_err;
  int         m_wrap;

  function automatic int dec(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) r = r | (int'(^(g >> i)) << i);
    return r;
  endfunction

  function automatic logic [3:0] gray(input int i);
    logic [3:0] b;
    b = i[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_item(input exp_t e);
    chk("bin_out", 8'(bin_out), 8'(e.bin));
    chk("valid", 8'(valid), 8'(e.valid));
    chk("up", 8'(up), 8'(e.up));
    chk("step_err", 8'(step_err), 8'(e.serr));
    chk("err_cnt", 8'(err_cnt), 8'(e.ecnt));
    chk("wrap_cnt", wrap_cnt, e.wcnt);
  endtask

  task automatic push_item(input logic [3:0] g, input logic clr);
    exp_t e;
    int   nb;
    e.g     = g;
    e.clr   = clr;
    e.bin   = 4'(dec(g));
    e.valid = 1'b0;
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      nb = $countones(g ^ m_prev);
      if (nb == 1) begin
        e.valid = 1'b1;
        m_up = (dec(g) == ((dec(m_prev) + 1) % 16));
        if (m_up && dec(m_prev) == 15 && m_wrap < 255) m_wrap++;
      end
      if (nb >= 2) begin
        if (clr) m_err = 0;
        if (m_err < 15) m_err++;
        m_serr = 1'b1;
      end else if (clr) begin
        m_err  = 0;
        m_serr = 1'b0;
      end
    end
    m_prev = g;
    e.up   = m_up;
    e.serr = m_serr;
    e.ecnt = 4'(m_err);
    e.wcnt = 8'(m_wrap);
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] g, input logic clr);
    exp_t e;
    push_item(g, clr);
    g_in    = g;
    clr_err = (sb.size() >= 3) ? sb[0].clr : 1'b0;
    @(posedge clk);
    #1;
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      compare_item(e);
    end else begin
      chk("valid_fill", 8'(valid), 8'd0);
    end
    @(negedge clk);
  endtask

  task automatic flush();
    exp_t e;
    while (sb.size() > 0) begin
      clr_err = sb[0].clr;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare_item(e);
      @(negedge clk);
    end
    clr_err = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] g);
    flush();
    reset   = 1'b1;
    clr_err = 1'b0;
    g_in    = g;
    #1;
    chk("rst_bin_out", 8'(bin_out), 8'd0);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_up", 8'(up), 8'd0);
    chk("rst_step_err", 8'(step_err), 8'd0);
    chk("rst_err_cnt", 8'(err_cnt), 8'd0);
    chk("rst_wrap_cnt", wrap_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_first = 1'b1;
    m_prev  = g;
    m_up    = 1'b0;
    m_serr  = 1'b0;
    m_err   = 0;
    m_wrap  = 0;
  endtask

  initial begin
    reset   = 1'b1;
    g_in    = 4'b0000;
    clr_err = 1'b0;
    @(negedge clk);

    // Reset with nonzero input, then INIT fill
    do_reset(4'b0110);
    repeat (3) cyc(4'b0110, 1'b0);

    // Count up through all codes, up-wrap, then down-wrap
    do_reset(4'b0000);
    cyc(4'b0000, 1'b0);
    for (int i = 1; i <= 16; i++) cyc(gray(i % 16), 1'b0);
    cyc(4'b1000, 1'b0);
    flush();
    chk("wrap_after_down", wrap_cnt, 8'd1);

    // Illegal steps, fault tracking and clear priority
    do_reset(4'b0001);
    cyc(4'b0001, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0011, 1'b0);
    cyc(4'b0010, 1'b0);
    cyc(4'b0110, 1'b0);
    cyc(4'b0101, 1'b1);
    cyc(4'b0101, 1'b1);
    cyc(4'b0100, 1'b0);
    cyc(4'b0111, 1'b0);
    cyc(4'b0111, 1'b1);
    flush();
    chk("cleared_step_err", 8'(step_err), 8'd0);
    chk("cleared_err_cnt", 8'(err_cnt), 8'd0);

    // Saturation of both counters
    do_reset(4'b0000);
    cyc(4'b0000, 1'b0);
    for (int k = 0; k < 20; k++) cyc((k % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
    for (int c = 0; c < 260; c++)
      for (int i = 1; i <= 16; i++) cyc(gray(i % 16), 1'b0);
    flush();
    chk("err_cnt_sat", 8'(err_cnt), 8'd15);
    chk("wrap_cnt_sat", wrap_cnt, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grey_count_monitor.md
# grey_count_monitor

Downstream consumer of the 4-bit Gray counter output. Synchronizes the incoming Gray code into the local clock domain, decodes it to binary, and checks that every change is a legal single-bit Gray step. Counts up-direction wrap-arounds and illegal steps, and raises a sticky fault flag. Sits between the Gray counter and any binary-domain logic that needs the count value.

## Interface
- WIDTH, 4, Gray/binary word width (≥2)
- SYNC_STAGES, 2, synchronizer depth on g_in (≥1)
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- g_in  input  WIDTH  Gray code from upstream counter; may be asynchronous to clk
- clr_err  input  1  synchronous clear of step_err/err_cnt; level, sampled on clk
- bin_out  output  WIDTH  decoded binary of the synchronized Gray value
- valid  output  1  one-cycle pulse per accepted single-bit step
- up  output  1  direction of last accepted step (1 = +1, 0 = −1)
- step_err  output  1  sticky flag: a multi-bit change was observed
- err_cnt  output  4  illegal-step count, saturates at 15
- wrap_cnt  output  8  count of up-steps from 2^WIDTH−1 to 0, saturates at 255

## Operation
- Reset (async assert, applies without a clock edge): synchronizer flops, g_prev, bin_out, valid, up, step_err, err_cnt, wrap_cnt = 0; FSM = INIT.
- Synchronizer: g_in → SYNC_STAGES flop chain → g_s. No other logic touches g_in.
- Decode: b[WIDTH−1] = g[WIDTH−1]; b[i] = b[i+1] ^ g[i] for i = WIDTH−2..0.
- Every edge outside reset: g_prev <= g_s; bin_out <= decode(g_s).
- Step classification: d = g_s ^ g_prev; n = popcount(d).
  - n = 0: hold; valid = 0.
  - n = 1: legal step. up = 1 if decode(g_s) == decode(g_prev)+1 mod 2^WIDTH, else 0. valid = 1 for one cycle. If up and decode(g_prev) = 2^WIDTH−1 and decode(g_s) = 0: wrap_cnt += 1 (saturating). Down-wraps (0 → max) are not counted and do not decrement.
  - n ≥ 2: illegal step; valid = 0; up holds; wrap_cnt unchanged.
- FSM states:
  - INIT: lasts SYNC_STAGES+1 edges after reset deassertion (pipeline fill). No classification, no valid, no errors. → TRACK.
  - TRACK: classify each edge. Illegal step → FAULT, step_err = 1, err_cnt += 1.
  - FAULT: decode and classify continue, with valid, up and wrap_cnt updated for legal steps. Each further illegal step increments err_cnt. clr_err = 1 → TRACK, step_err = 0, err_cnt = 0.
- clr_err in TRACK: err_cnt = 0 (already 0); no other effect.
- clr_err and an illegal step on the same edge: the error wins. State = FAULT, step_err = 1, err_cnt = 1.
- Saturation: err_cnt holds at 15 and wrap_cnt holds at 255; neither wraps.

## Timing
- Latency: a g_in change sampled at edge k appears on g_s after edge k+SYNC_STAGES−1. bin_out, valid, up, step_err, err_cnt and wrap_cnt update at edge k+SYNC_STAGES. With the defaults this is 2 edges after sampling, or 3 edges counting the capture edge.
- All outputs are registered; no combinational path from any input to any output.
- valid is high for exactly one cycle per legal step. Back-to-back legal steps give back-to-back valid pulses.
- Reset deassertion mid-operation: re-enters INIT. The first SYNC_STAGES+1 edges produce no valid and no errors, even if g_in is nonzero.

## Test plan
- Reset: drive g_in = 4'b0110, assert reset with no clock → all outputs 0 immediately. Release reset, then wait 3 edges (INIT) → bin_out = 4, valid never pulses, step_err = 0.
- Count up: after INIT, drive 0000, 0001, 0011, 0010, 0110, one per cycle → bin_out = 0, 1, 2, 3, 4, each 2 edges after sampling; valid pulses 4 times; up = 1.
- Wrap: drive 1000 (bin 15) then 0000 → valid = 1, up = 1, wrap_cnt 0→1. Then 0000 → 1000 → valid = 1, up = 0, wrap_cnt stays 1.
- Illegal step: 0001 → 0010 (two bits differ) → valid = 0, step_err = 1, err_cnt = 1, bin_out = 3, FSM = FAULT. A following legal 0010 → 0110 → valid = 1 while step_err stays 1.
- Clear priority: in FAULT with err_cnt = 2, pulse clr_err on the same edge as an illegal 0110 → 0101 → step_err = 1, err_cnt = 1. Pulse clr_err alone → step_err = 0, err_cnt = 0, FSM = TRACK.
- Saturation: force 20 illegal steps → err_cnt = 15. Perform 260 full up-cycles → wrap_cnt = 255.
